frame_mem_arb: RTL

FRAME_MEM_ARB -- requirements
Module: frame_mem_arb

---
 rtl/frame_mem_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/frame_mem_arb.sv
// frame_mem_arb
//   Arbitrates a single-port frame memory between a capture (write) side and
//   a processing (read) side. Each grant is a fixed BURST-word burst followed
//   by one GAP cycle that drains the trailing write strobe, so writes and reads
//   never share a cycle. Read data returns RD_LAT cycles after each mem_re and
//   may overlap the bursts that follow.
//
//   Optional build macro: ARB_WR_PRIO_EN -- strict write priority in IDLE
//   (default build: round-robin, read wins the first tie after reset).
//
// Ports
//   cap_clk, reset_l        clock, async active-low reset
//   frame_start             pulse: restart write addressing at word 0
//   wr_req/wr_din           capture FIFO has >= BURST words / FIFO data
//   wr_grant/wr_rdreq       write burst active / FIFO pop
//   rd_req                  read burst request
//   rd_grant/rd_dout/rd_dvalid  read burst active / returned data / valid
//   mem_addr/mem_we/mem_wdat/mem_re/mem_rdat  memory port
//   frame_wr_done           pulse when the last word of a frame is written
module frame_mem_arb #(
  parameter int IW     = 640,
  parameter int IH     = 512,
  parameter int BURST  = 64,
  parameter int AW     = 19,
  parameter int DW     = 24,
  parameter int RD_LAT = 2
) (
  input  logic          cap_clk,
  input  logic          reset_l,
  input  logic          frame_start,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_din,
  output logic          wr_grant,
  output logic          wr_rdreq,
  input  logic          rd_req,
  output logic          rd_grant,
  output logic [DW-1:0] rd_dout,
  output logic          rd_dvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdat,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdat,
  output logic          frame_wr_done
);

  localparam int            FRAME_WORDS = IW * IH;
  localparam logic [AW-1:0] LAST_ADDR   = AW'(FRAME_WORDS - 1);
  localparam int            CW          = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic            fs_pend;
  logic            last_wr;     // 1: write side was served last
  logic            we_q;
  logic [RD_LAT:1] vld_pipe;
  logic            grant_wr, grant_rd;
  logic            fs_clr_now;

  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    wr_rdreq  = 1'b0;
    rd_grant  = 1'b0;
    mem_re    = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARB_WR_PRIO_EN
        grant_wr = wr_req;
        grant_rd = rd_req & ~wr_req;
`else
        grant_wr = wr_req & (~rd_req | ~last_wr);
        grant_rd = rd_req & (~wr_req | last_wr);
`endif
        if (grant_wr)      state_nxt = WR_BURST;
        else if (grant_rd) state_nxt = RD_BURST;
      end
      WR_BURST: begin
        wr_grant = 1'b1;
        wr_rdreq = 1'b1;
        if (cnt == CNT_LAST) state_nxt = GAP;
      end
      RD_BURST: begin
        rd_grant = 1'b1;
        mem_re   = 1'b1;
        if (cnt == CNT_LAST) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l)                                  cnt <= '0;
    else if (state == WR_BURST || state == RD_BURST) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    else                                           cnt <= '0;
  end

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l)                              last_wr <= 1'b1;
    else if (state == IDLE && (grant_wr | grant_rd)) last_wr <= grant_wr;
  end

  // A restart is safe to apply at once whenever no write is in flight; the
  // first WR_BURST cycle still counts, since its first strobe is a cycle away.
  assign fs_clr_now = frame_start &&
                      (state == IDLE || state == RD_BURST || (state == WR_BURST && cnt == '0));

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l)                                           fs_pend <= 1'b0;
    else if (state == GAP)                                  fs_pend <= 1'b0;
    else if (frame_start && state == WR_BURST && cnt != '0) fs_pend <= 1'b1;
  end

  // GAP carries the last write of a burst; a pending restart overrides its
  // address increment so the next burst starts at word 0.
  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l)                                             wr_addr <= '0;
    else if (fs_clr_now || (state == GAP && (fs_pend || frame_start))) wr_addr <= '0;
    else if (we_q)                                            wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
  end

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l)    rd_addr <= '0;
    else if (mem_re) rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
  end

  always_ff @(posedge cap_clk or negedge reset_l) begin
    if (!reset_l) begin
      we_q     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      we_q        <= wr_rdreq;
      vld_pipe[1] <= mem_re;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = we_q ? wr_addr : (mem_re ? rd_addr : '0);
  assign mem_wdat      = we_q ? wr_din : '0;
  assign rd_dvalid     = vld_pipe[RD_LAT];
  assign rd_dout       = rd_dvalid ? mem_rdat : '0;
  assign frame_wr_done = we_q && (wr_addr == LAST_ADDR);

endmodule
